// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer sequencer: Buzzer mode codes, request patterns,
// sequencer states and the one-entry pending request slot.
package buzzer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_CHIRP = 2'b10,
    MODE_SIREN = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    PAT_NONE   = 2'b00,
    PAT_CHIRP1 = 2'b01,
    PAT_CHIRP2 = 2'b10,
    PAT_CHIRP3 = 2'b11
  } pattern_t;

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP,
    SIREN
  } state_t;

  // Pending request: a siren flag or a chirp count (1..3).
  typedef struct packed {
    logic       siren;
    logic [1:0] beeps;
  } slot_t;

  function automatic int max_u(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The pattern encoding doubles as the chirp count.
  function automatic logic [1:0] chirp_count(input pattern_t p);
    return 2'(p);
  endfunction

endpackage

// File: rtl/buzzer_sequencer_seq_timer.sv
// seq_timer: loadable saturating down counter. load wins over en; expired is
// high while the count sits at zero, so a load of N-1 gives N enabled cycles.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Count down toward zero and hold there; never wraps.
  always_ff @(posedge clk) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: turns chirp/siren requests into Buzzer mode codes, waits
// on buzz_done per tone and inserts a Mode 00 gap between tones so the
// Buzzer's ms counter clears.
// Optional build macro SEQ_TIMEOUT_EN adds a per-tone watchdog that sets a
// sticky timeout_err; without it timeout_err is tied low and tones wait forever.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int GAP_CYCLES     = 200_000,
  parameter int TIMEOUT_CYCLES = 300_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_pattern,
  input  logic       req_siren,
  output logic       req_ready,
  input  logic       alarm_clear,
  input  logic       buzz_done,
  output logic [1:0] mode,
  output logic       busy,
  output logic       siren_active,
  output logic       timeout_err
);

  localparam int            CW     = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  state_t     state, state_n;
  mode_t      mode_c;
  slot_t      slot;
  logic       slot_full, slot_acc, slot_clr;
  logic [1:0] beep_cnt, beep_n;
  logic       siren_n, first_cyc, tmo_set;
  logic       siren_req, bypass;
  logic       gap_load, gap_exp, wdg_exp;

  // clock frequency only documents the gap sizing; no logic depends on it
  logic unused_cfg;
  assign unused_cfg = ^CLK_HZ;

  // Clear beats a same-cycle siren request; outside IDLE a siren skips the slot.
  assign siren_req = req_valid && req_siren && !alarm_clear;
  assign bypass    = siren_req && (state != IDLE);
  assign slot_acc  = req_valid && !slot_full && !bypass &&
                     (req_siren ? !alarm_clear : (req_pattern != PAT_NONE));
  assign req_ready = !slot_full;

  // One-entry pending slot; filled on accept, emptied when IDLE picks it up.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full <= 1'b0;
      slot      <= '0;
    end else if (slot_acc) begin
      slot_full <= 1'b1;
      slot      <= {req_siren, chirp_count(pattern_t'(req_pattern))};
    end else if (slot_clr) begin
      slot_full <= 1'b0;
    end
  end

  // Gap timer restarts on every entry into GAP.
  assign gap_load = (state_n == GAP) && (state != GAP);

  seq_timer #(.W(CW)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LD),
    .en       (state == GAP),
    .expired  (gap_exp)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES - 1);
  logic wdg_load, wdg_en;

  assign wdg_en   = (state == TONE) || (state == SIREN);
  assign wdg_load = ((state_n == TONE) || (state_n == SIREN)) && (state_n != state);

  seq_timer #(.W(CW)) u_wdg (
    .clk      (clk),
    .reset    (reset),
    .load     (wdg_load),
    .load_val (TMO_LD),
    .en       (wdg_en),
    .expired  (wdg_exp)
  );

  // Sticky watchdog error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)        timeout_err <= 1'b0;
    else if (tmo_set) timeout_err <= 1'b1;
  end
`else
  logic unused_tmo;
  assign wdg_exp     = 1'b0;
  assign unused_tmo  = tmo_set;
  assign timeout_err = 1'b0;
`endif

  // State, chirp count and siren flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beep_cnt     <= 2'd0;
      siren_active <= 1'b0;
      first_cyc    <= 1'b0;
    end else begin
      state        <= state_n;
      beep_cnt     <= beep_n;
      siren_active <= siren_n;
      first_cyc    <= (state_n != state);
    end
  end

  // Next-state, counters and mode decode.
  always_comb begin
    state_n  = state;
    beep_n   = beep_cnt;
    siren_n  = siren_active && !alarm_clear;
    slot_clr = 1'b0;
    tmo_set  = 1'b0;
    mode_c   = MODE_OFF;
    case (state)
      IDLE: begin
        if (slot_full) begin
          slot_clr = 1'b1;
          if (slot.siren) begin
            // siren starts with a gap so the Buzzer counter is clean
            siren_n = !alarm_clear;
            beep_n  = 2'd0;
            state_n = GAP;
          end else begin
            beep_n  = slot.beeps;
            state_n = TONE;
          end
        end
      end
      TONE: begin
        mode_c = MODE_CHIRP;
        // done may still be high from the previous tone on the entry cycle
        if (buzz_done && !first_cyc) begin
          beep_n  = (beep_cnt != 2'd0) ? beep_cnt - 2'd1 : 2'd0;
          state_n = GAP;
        end
        if (bypass) begin
          siren_n = 1'b1;
          beep_n  = 2'd0;
          state_n = GAP;
        end
        if (wdg_exp) begin
          tmo_set = 1'b1;
          beep_n  = 2'd0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (bypass) begin
          siren_n = 1'b1;
          beep_n  = 2'd0;
        end
        if (gap_exp) begin
          if (siren_n)              state_n = SIREN;
          else if (beep_n != 2'd0)  state_n = TONE;
          else                      state_n = IDLE;
        end
      end
      SIREN: begin
        mode_c = MODE_SIREN;
        // clear and done both leave via GAP; siren_n already reflects clear
        if (alarm_clear || buzz_done) state_n = GAP;
        if (wdg_exp) begin
          tmo_set = 1'b1;
          beep_n  = 2'd0;
          state_n = GAP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mode = mode_c;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with GAP_CYCLES=4, TIMEOUT_CYCLES=50.
// Buzzer model raises done 10 cycles after mode goes 1x and holds it 3 cycles.
module tb_buzzer_sequencer;

  localparam int GAP = 4;
  localparam int TMO = 50;
  localparam int TON = 11;  // mode-1x cycles per tone with the done model

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_pattern = 2'b00;
  logic       req_siren = 1'b0;
  logic       alarm_clear = 1'b0;
  logic       req_ready, busy, siren_active, timeout_err, buzz_done;
  logic [1:0] mode;

  int n_chk = 0;
  int n_fail = 0;
  int mcnt = 0;
  int hold = 0;
  bit done_en = 1'b1;
  bit done_force = 1'b0;

  buzzer_sequencer #(
    .CLK_HZ         (100_000_000),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_pattern  (req_pattern),
    .req_siren    (req_siren),
    .req_ready    (req_ready),
    .alarm_clear  (alarm_clear),
    .buzz_done    (buzz_done),
    .mode         (mode),
    .busy         (busy),
    .siren_active (siren_active),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Buzzer model: ms counter clears while mode[1]=0
  assign buzz_done = done_force || (done_en && hold != 0);
  always @(posedge clk) begin
    if (mode[1]) mcnt <= mcnt + 1;
    else         mcnt <= 0;
    if (hold != 0)                 hold <= hold - 1;
    else if (mode[1] && mcnt == 9) hold <= 3;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_mode(input string tag, input logic [1:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, mode, e);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [1:0] pat, input logic sir);
    req_valid = 1'b1; req_pattern = pat; req_siren = sir;
    @(negedge clk);
    req_valid = 1'b0; req_pattern = 2'b00; req_siren = 1'b0;
  endtask

  task automatic clear_pulse();
    alarm_clear = 1'b1;
    @(negedge clk);
    alarm_clear = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_mode", mode, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_siren", siren_active, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    reset = 1'b0;
    cyc(1);

    // CHIRP1: one tone, gap, idle
    send(2'b01, 1'b0);
    chk("c1_ready", req_ready, 1'b0);
    exp_mode("c1_lat", 2'b00, 1);
    exp_mode("c1_tone", 2'b10, TON);
    exp_mode("c1_gap", 2'b00, GAP);
    chk("c1_busy", busy, 1'b0);
    chk("c1_rdy_idle", req_ready, 1'b1);
    cyc(2);

    // CHIRP3: three tones separated by gaps
    send(2'b11, 1'b0);
    exp_mode("c3_lat", 2'b00, 1);
    for (int t = 0; t < 3; t++) begin
      exp_mode("c3_tone", 2'b10, TON);
      exp_mode("c3_gap", 2'b00, GAP);
    end
    chk("c3_busy", busy, 1'b0);
    cyc(2);

    // done held high: ignored on the first TONE cycle, taken on the second
    done_force = 1'b1;
    send(2'b01, 1'b0);
    exp_mode("df_lat", 2'b00, 1);
    exp_mode("df_tone", 2'b10, 2);
    exp_mode("df_gap", 2'b00, GAP);
    done_force = 1'b0;
    chk("df_busy", busy, 1'b0);
    cyc(2);

    // siren from IDLE: pre-gap, then mode 11 until cleared
    send(2'b00, 1'b1);
    exp_mode("si_lat", 2'b00, 1 + GAP);
    chk("si_active", siren_active, 1'b1);
    exp_mode("si_on", 2'b11, 2);
    clear_pulse();
    chk("si_cleared", siren_active, 1'b0);
    exp_mode("si_gap", 2'b00, GAP);
    chk("si_busy", busy, 1'b0);
    cyc(2);

    // CHIRP2 preempted by siren, chirp queued during siren plays after clear
    send(2'b10, 1'b0);
    exp_mode("pe_lat", 2'b00, 1);
    exp_mode("pe_tone", 2'b10, 3);
    send(2'b00, 1'b1);
    chk("pe_active", siren_active, 1'b1);
    exp_mode("pe_gap", 2'b00, GAP);
    exp_mode("pe_sir1", 2'b11, TON);
    exp_mode("pe_gap2", 2'b00, GAP);
    exp_mode("pe_sir2", 2'b11, 3);
    send(2'b01, 1'b0);
    chk("pe_slot", req_ready, 1'b0);
    clear_pulse();
    chk("pe_cleared", siren_active, 1'b0);
    exp_mode("pe_gap3", 2'b00, GAP + 1);
    exp_mode("pe_chirp", 2'b10, TON);
    exp_mode("pe_gap4", 2'b00, GAP);
    chk("pe_busy", busy, 1'b0);
    chk("pe_rdy", req_ready, 1'b1);
    cyc(2);

    // request while slot full is dropped
    send(2'b01, 1'b0);
    chk("dr_ready", req_ready, 1'b0);
    send(2'b11, 1'b0);
    exp_mode("dr_tone", 2'b10, TON);
    exp_mode("dr_gap", 2'b00, GAP);
    exp_mode("dr_idle", 2'b00, 3);
    chk("dr_busy", busy, 1'b0);

    // alarm_clear together with siren request: clear wins
    req_valid = 1'b1; req_siren = 1'b1; alarm_clear = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_siren = 1'b0; alarm_clear = 1'b0;
    chk("ac_siren", siren_active, 1'b0);
    chk("ac_ready", req_ready, 1'b1);
    exp_mode("ac_idle", 2'b00, 2 + GAP + 2);
    chk("ac_busy", busy, 1'b0);
    chk("ac_siren2", siren_active, 1'b0);

    // reset mid-tone flushes state and pending slot
    send(2'b11, 1'b0);
    exp_mode("rm_lat", 2'b00, 1);
    exp_mode("rm_tone", 2'b10, 2);
    send(2'b01, 1'b0);
    chk("rm_slot", req_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm_mode", mode, 2'b00);
    chk("rm_busy", busy, 1'b0);
    chk("rm_ready", req_ready, 1'b1);
    exp_mode("rm_idle", 2'b00, 6);
    chk("rm_busy2", busy, 1'b0);

    // done never arrives
    done_en = 1'b0;
    send(2'b01, 1'b0);
    exp_mode("to_lat", 2'b00, 1);
`ifdef SEQ_TIMEOUT_EN
    exp_mode("to_tone", 2'b10, TMO);
    chk("to_err", timeout_err, 1'b1);
    exp_mode("to_gap", 2'b00, GAP);
    chk("to_busy", busy, 1'b0);
    chk("to_sticky", timeout_err, 1'b1);
`else
    exp_mode("to_wait", 2'b10, TMO + 10);
    chk("to_err_off", timeout_err, 1'b0);
    chk("to_busy", busy, 1'b1);
`endif
    done_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("to_rst_err", timeout_err, 1'b0);
    chk("to_rst_mode", mode, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
